// File: rtl/router_pkt_tx_pkg.sv
// Shared definitions for the router packet transmitter: FSM states, field widths
// and request/header helpers.
package router_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int DATA_W    = 8;
  localparam int PTR_W     = 6;
  localparam int MAX_LEN   = 63;
  localparam int BUF_DEPTH = MAX_LEN + 1;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // Port 3 does not exist on the router and a zero-length packet carries nothing.
  function automatic logic isValidReq(input logic [ADDR_W-1:0] addr,
                                      input logic [LEN_W-1:0]  len);
    return (addr != ADDR_INVALID) && (len != '0);
  endfunction

  function automatic logic [DATA_W-1:0] makeHeader(input logic [LEN_W-1:0]  len,
                                                   input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-side signals of the packet transmitter.
// The master side drives requests, payload and busy; the slave is the transmitter.
interface router_pkt_tx_if;
  import router_pkg::*;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              req_ready;
  logic              req_rej;
  logic              pl_valid;
  logic [DATA_W-1:0] pl_data;
  logic              pl_ready;
  logic              busy;
  logic              pkt_valid;
  logic [DATA_W-1:0] data_out;
  logic              pkt_done;

  modport master (
    output req_valid, req_addr, req_len, pl_valid, pl_data, busy,
    input  req_ready, req_rej, pl_ready, pkt_valid, data_out, pkt_done
  );

  modport slave (
    input  req_valid, req_addr, req_len, pl_valid, pl_data, busy,
    output req_ready, req_rej, pl_ready, pkt_valid, data_out, pkt_done
  );

endinterface

// File: rtl/router_pkt_tx_buf.sv
// 64x8 simple dual-port payload buffer: one synchronous write port and one
// asynchronous read port, so the transmitter can register the byte it reads.
module router_pkt_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              i_wrEn,
  input  logic [PTR_W-1:0]  i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [PTR_W-1:0]  i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];

  // Contents are left untouched by reset; a packet is always fully rewritten before use.
  always_ff @(posedge clock) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a requested payload, then streams header,
// payload and XOR parity into the router, holding each byte while busy is high.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IDLE_GAP = 2
) (
  input logic            clock,
  input logic            reset,
  router_pkt_tx_if.slave bus
);

  localparam logic [15:0] GAP_LAST = (IDLE_GAP > 0) ? 16'(IDLE_GAP - 1) : 16'd0;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [DATA_W-1:0] r_parity;
  logic [DATA_W-1:0] r_dataOut;
  logic [15:0]       r_gapCnt;
  logic              r_reqReady;
  logic              r_reqRej;
  logic              r_plReady;
  logic              r_pktValid;
  logic              r_pktDone;

  logic              w_wrEn;
  logic              w_accept;
  logic [DATA_W-1:0] w_rdData;

  assign w_wrEn   = r_plReady & bus.pl_valid;
  assign w_accept = ~bus.busy;

  router_pkt_buf u_buf (
    .clock    (clock),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (r_wrPtr),
    .i_wrData (bus.pl_data),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdData)
  );

  // r_rdPtr always points at the next payload byte to load into data_out, so the
  // last payload byte is on the wire once r_rdPtr has caught up with r_len.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_parity   <= '0;
      r_dataOut  <= '0;
      r_gapCnt   <= '0;
      r_reqReady <= 1'b1;
      r_reqRej   <= 1'b0;
      r_plReady  <= 1'b0;
      r_pktValid <= 1'b0;
      r_pktDone  <= 1'b0;
    end else begin
      r_reqRej  <= 1'b0;
      r_pktDone <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (isValidReq(bus.req_addr, bus.req_len)) begin
              r_addr     <= bus.req_addr;
              r_len      <= bus.req_len;
              r_wrPtr    <= '0;
              r_rdPtr    <= '0;
              r_parity   <= '0;
              r_reqReady <= 1'b0;
              r_plReady  <= 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_reqRej <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_wrEn) begin
            r_wrPtr <= r_wrPtr + 1'b1;
            if (r_wrPtr == r_len - 1'b1) begin
              r_plReady  <= 1'b0;
              r_pktValid <= 1'b1;
              r_dataOut  <= makeHeader(r_len, r_addr);
              r_state    <= S_HEADER;
            end
          end
        end
        S_HEADER: begin
          if (w_accept) begin
            r_parity  <= r_parity ^ r_dataOut;
            r_dataOut <= w_rdData;
            r_rdPtr   <= r_rdPtr + 1'b1;
            r_state   <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            r_parity <= r_parity ^ r_dataOut;
            if (r_rdPtr == r_len) begin
              r_pktValid <= 1'b0;
              r_dataOut  <= r_parity ^ r_dataOut;
              r_state    <= S_PARITY;
            end else begin
              r_dataOut <= w_rdData;
              r_rdPtr   <= r_rdPtr + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_accept) begin
            r_pktDone <= 1'b1;
            r_dataOut <= '0;
            if (IDLE_GAP == 0) begin
              r_reqReady <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_gapCnt <= '0;
              r_state  <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gapCnt == GAP_LAST) begin
            r_reqReady <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_gapCnt <= r_gapCnt + 16'd1;
          end
        end
        default: begin
          r_reqReady <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_reqReady;
  assign bus.req_rej   = r_reqRej;
  assign bus.pl_ready  = r_plReady;
  assign bus.pkt_valid = r_pktValid;
  assign bus.data_out  = r_dataOut;
  assign bus.pkt_done  = r_pktDone;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Testbench for router_pkt_tx: directed and randomized packets checked against
// a byte-stream model (header, payload, XOR parity, idle gap).
module tb_router_pkt_tx;

  localparam int IDLE_GAP    = 2;
  localparam int CYCLE_LIMIT = 3000;

  logic       clock;
  logic       reset;
  int         total;
  int         bad;
  logic [7:0] payload[$];

  router_pkt_tx_if bus ();

  router_pkt_tx #(.IDLE_GAP(IDLE_GAP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    bus.req_valid = 1'b0;
    bus.req_addr  = 2'd0;
    bus.req_len   = 6'd0;
    bus.pl_valid  = 1'b0;
    bus.pl_data   = 8'd0;
    bus.busy      = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pkt_valid"}, bus.pkt_valid, 0);
    checkOutput({tag, "_data_out"},  bus.data_out,  0);
    checkOutput({tag, "_pl_ready"},  bus.pl_ready,  0);
    checkOutput({tag, "_req_rej"},   bus.req_rej,   0);
    checkOutput({tag, "_pkt_done"},  bus.pkt_done,  0);
    checkOutput({tag, "_req_ready"}, bus.req_ready, 1);
  endtask

  task automatic fillPayload(input int len);
    payload.delete();
    for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
  endtask

  // Issues one request for the current payload queue and follows the packet out.
  // Called and returning on a falling edge; abortAfter >= 0 stops once that many
  // stream bytes have been accepted so the caller can reset mid-packet.
  task automatic applyStimulus(input logic [1:0] addr, input int len, input int plPct,
                               input int busyPct, input int holdIdx, input int holdCycles,
                               input int abortAfter);
    logic [7:0] expStream[$];
    logic [7:0] expParity;
    int idx;
    int cycles;
    int holdLeft;
    int holdSeen;
    int gap;
    int dones;
    logic early;
    logic accepted;

    expStream.push_back(8'(len * 4 + int'(addr)));
    foreach (payload[i]) expStream.push_back(payload[i]);
    expParity = 8'd0;
    foreach (expStream[i]) expParity = expParity ^ expStream[i];

    checkOutput("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = 6'(len);
    @(negedge clock);
    bus.req_valid = 1'b0;
    checkOutput("req_rej_valid", bus.req_rej, 0);
    checkOutput("pl_ready_load", bus.pl_ready, 1);

    idx = 0;
    cycles = 0;
    early = 1'b0;
    while (idx < len && cycles < CYCLE_LIMIT) begin
      if (bus.pkt_valid) early = 1'b1;
      bus.pl_valid = ($urandom_range(99) < plPct);
      bus.pl_data  = bus.pl_valid ? payload[idx] : 8'($urandom);
      @(negedge clock);
      if (bus.pl_valid) idx++;
      cycles++;
    end
    bus.pl_valid = 1'b0;
    checkOutput("load_done", idx, len);
    checkOutput("no_early_valid", early, 0);
    checkOutput("pl_ready_after_load", bus.pl_ready, 0);

    // Requests and payload strobes are waved around while sending to show they are ignored.
    idx = 0;
    cycles = 0;
    holdLeft = holdCycles;
    holdSeen = 0;
    while (idx < expStream.size() && cycles < CYCLE_LIMIT) begin
      checkOutput($sformatf("pkt_valid_b%0d", idx), bus.pkt_valid, 1);
      checkOutput($sformatf("data_b%0d", idx), bus.data_out, expStream[idx]);
      if (idx == abortAfter) break;
      if (idx == holdIdx) holdSeen++;
      if (idx == holdIdx && holdLeft > 0) begin
        bus.busy = 1'b1;
        holdLeft--;
      end else begin
        bus.busy = ($urandom_range(99) < busyPct);
      end
      bus.req_valid = 1'($urandom_range(1));
      bus.req_addr  = 2'($urandom_range(2));
      bus.req_len   = 6'($urandom_range(63, 1));
      bus.pl_valid  = 1'($urandom_range(1));
      bus.pl_data   = 8'($urandom);
      @(negedge clock);
      if (!bus.busy) idx++;
      cycles++;
    end
    idleInputs();

    if (abortAfter < 0) begin
      checkOutput("stream_done", idx, expStream.size());
      if (holdIdx >= 0) checkOutput("hold_cycles", holdSeen, holdCycles + 1);

      cycles = 0;
      accepted = 1'b0;
      while (!accepted && cycles < 200) begin
        checkOutput("parity_pkt_valid", bus.pkt_valid, 0);
        checkOutput("parity_data", bus.data_out, expParity);
        bus.busy = ($urandom_range(99) < busyPct);
        @(negedge clock);
        accepted = !bus.busy;
        cycles++;
      end
      bus.busy = 1'b0;
      checkOutput("parity_accepted", accepted, 1);

      gap = 0;
      dones = 0;
      while (bus.req_ready !== 1'b1 && gap < 50) begin
        checkOutput("gap_pkt_valid", bus.pkt_valid, 0);
        checkOutput("gap_data", bus.data_out, 0);
        if (bus.pkt_done) dones++;
        gap++;
        @(negedge clock);
      end
      checkOutput("gap_cycles", gap, IDLE_GAP);
      checkOutput("pkt_done_count", dones, 1);
      checkOutput("idle_pkt_done", bus.pkt_done, 0);
      checkOutput("idle_data", bus.data_out, 0);
    end
  endtask

  task automatic applyReject(input logic [1:0] addr, input logic [5:0] len);
    logic seen;
    checkOutput("rej_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    @(negedge clock);
    bus.req_valid = 1'b0;
    checkOutput("rej_pulse", bus.req_rej, 1);
    checkOutput("rej_stay_idle", bus.req_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.pl_valid = 1'b1;
      bus.pl_data  = 8'($urandom);
      @(negedge clock);
      if (i == 0) checkOutput("rej_pulse_end", bus.req_rej, 0);
      if (bus.pkt_valid || bus.pl_ready) seen = 1'b1;
    end
    bus.pl_valid = 1'b0;
    checkOutput("rej_no_activity", seen, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idleInputs();
    @(negedge clock);
    @(negedge clock);
    checkResetState("reset");
    reset = 1'b0;
    @(negedge clock);
    checkResetState("post_reset");

    $display("[TB] basic packet addr=1 len=3");
    payload.delete();
    payload.push_back(8'hA1);
    payload.push_back(8'hA2);
    payload.push_back(8'hA3);
    applyStimulus(2'd1, 3, 100, 0, -1, 0, -1);

    $display("[TB] same packet with busy held on A2");
    applyStimulus(2'd1, 3, 100, 0, 2, 3, -1);

    $display("[TB] rejected requests");
    applyReject(2'd3, 6'd5);
    applyReject(2'd0, 6'd0);

    $display("[TB] maximum length with gappy payload");
    fillPayload(63);
    applyStimulus(2'($urandom_range(2)), 63, 50, 0, -1, 0, -1);

    $display("[TB] reset in the middle of the payload");
    fillPayload(4);
    applyStimulus(2'd0, 4, 100, 0, -1, 0, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_pkt_valid", bus.pkt_valid, 0);
    checkOutput("abort_data_out", bus.data_out, 0);
    checkOutput("abort_req_ready", bus.req_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    payload.delete();
    payload.push_back(8'h5C);
    applyStimulus(2'd2, 1, 100, 0, -1, 0, -1);

    $display("[TB] back-to-back random packets");
    for (int p = 0; p < 6; p++) begin
      int lenSel;
      lenSel = int'($urandom_range(63, 1));
      fillPayload(lenSel);
      applyStimulus(2'($urandom_range(2)), lenSel, 70, 30, -1, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 2, idle cycles inserted after each parity byte.
REQ-002 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  packet request strobe.
REQ-005 SHALL have port req_addr  in  2  destination port, 0..2 valid.
REQ-006 SHALL have port req_len  in  6  payload length, 1..63 valid.
REQ-007 SHALL have port req_ready  out  1  high only in IDLE.
REQ-008 SHALL have port req_rej  out  1  one-cycle pulse, invalid request dropped.
REQ-009 SHALL have port pl_valid  in  1  payload byte valid.
REQ-010 SHALL have port pl_data  in  8  payload byte.
REQ-011 SHALL have port pl_ready  out  1  high only in LOAD.
REQ-012 SHALL have port busy  in  1  router busy, hold current byte.
REQ-013 SHALL have port pkt_valid  out  1  router packet-valid.
REQ-014 SHALL have port data_out  out  8  byte to router data_in.
REQ-015 SHALL have port pkt_done  out  1  one-cycle pulse when parity byte accepted.

Function
REQ-016 SHALL implement states IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
REQ-017 SHALL, in IDLE, accept req_valid&req_ready: valid addr/len -> latch both, go LOAD; addr==3 or len==0 -> pulse req_rej next cycle, stay IDLE.
REQ-018 SHALL, in LOAD, write pl_data into a 64x8 buffer on each pl_valid&pl_ready; go HEADER the cycle after the len-th byte; pl_valid gaps only stall.
REQ-019 SHALL present header = {len[5:0], addr[1:0]} in HEADER with pkt_valid=1.
REQ-020 SHALL treat a byte as accepted on a rising edge with busy==0 in HEADER/PAYLOAD/PARITY; with busy==1 data_out and pkt_valid held stable.
REQ-021 SHALL, in PAYLOAD, present buffer bytes in write order with pkt_valid=1; after len accepted bytes go PARITY.
REQ-022 SHALL compute parity = XOR of header and all payload bytes, accumulated on acceptance.
REQ-023 SHALL, in PARITY, drive pkt_valid=0, data_out=parity; on acceptance pulse pkt_done, go GAP.
REQ-024 SHALL, in GAP, drive pkt_valid=0, data_out=0 for IDLE_GAP cycles, then IDLE; IDLE_GAP=0 goes directly IDLE.
REQ-025 SHALL register pkt_valid and data_out; zero-busy throughput one byte per cycle, header to parity len+2 cycles.
REQ-026 SHALL ignore req_valid outside IDLE and pl_valid outside LOAD.
REQ-027 SHALL use 6-bit read/write pointers plus length count; len=63 uses 63 entries, no wrap past 63.

Reset
REQ-028 SHALL on reset go IDLE, clear pointers, parity, gap counter.
REQ-029 SHALL reset pkt_valid=0, data_out=0x00, pl_ready=0, req_rej=0, pkt_done=0, req_ready=1.
REQ-030 SHALL, on reset mid-packet, abandon packet without emitting parity; buffer contents need not clear.

Structure
REQ-031 SHALL place state encoding, invalid address constant 2'b11, max length 63 in shared package router_pkg.
REQ-032 SHALL instantiate one sub-module router_pkt_buf (64x8 simple dual-port buffer, one write, one read port).

Verification
REQ-033 SHALL cover: addr=1, len=3, payload A1,A2,A3, busy=0 -> data_out 0D,A1,A2,A3 with pkt_valid=1, then AD with pkt_valid=0, one pkt_done.
REQ-034 SHALL cover: same packet, busy=1 three cycles while A2 presented -> A2 held four cycles, parity still AD.
REQ-035 SHALL cover: req_addr=3, len=5 -> req_rej one cycle, pkt_valid never rises, pl_ready stays 0.
REQ-036 SHALL cover: len=63, pl_valid toggling 50% -> header 0xFC|addr only after 63rd byte, 63 bytes in order, correct XOR.
REQ-037 SHALL cover: reset in PAYLOAD after 2 of 4 bytes -> pkt_valid=0 immediately, next addr=2 len=1 packet correct.
REQ-038 SHALL cover: back-to-back requests, IDLE_GAP=2 -> exactly 2 cycles pkt_valid=0, data_out=0 after parity before req_ready.
